dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences the MEM stage of the pipelined MIPS core against a variable-latency data memory.
//  Takes the stage-M control/data outputs of the EX/MEM pipeline register and issues a req/ack
//  transaction to data memory for every load or store.
//  Drives stall_M to freeze IF/ID, ID/EX and EX/MEM until the access completes.
//  Halts the pipeline on a bus error, timeout or misaligned address.
// PARAMETERS
//  TIMEOUT   255  max cycles in ACCESS without ack/err before a timeout error (1..2^CNT_W-1)
//  CNT_W     8    width of the timeout counter
// PORTS
//  clk            in   1   pipeline clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  memtoreg_M     in   1   stage-M instruction is a load
//  memwrite_M     in   1   stage-M instruction is a store
//  ALU_out_M      in   32  effective byte address
//  write_data_M   in   32  store data
//  dmem_req       out  1   memory request, held until ack/err
//  dmem_we        out  1   1=write, 0=read; stable while dmem_req=1
//  dmem_addr      out  32  byte address; stable while dmem_req=1
//  dmem_wdata     out  32  write data; stable while dmem_req=1
//  dmem_ack       in   1   access complete; rdata valid same cycle for reads
//  dmem_err       in   1   access failed
//  dmem_rdata     in   32  read data
//  stall_M        out  1   1 = hold all pipeline registers up to and including EX/MEM
//  read_data_M    out  32  load data, valid in DONE, held until the next load completes
//  bus_error      out  1   sticky error flag, cleared only by reset
//  err_cause      out  2   00 none, 01 dmem_err, 10 timeout, 11 misaligned
//  err_addr       out  32  ALU_out_M of the faulting access
// BEHAVIOUR
//  Reset:
//   - state=IDLE; all outputs, the counter and all registered data are 0.
//  Terms:
//   - mem_op = memtoreg_M | memwrite_M.
//   - stall_M = (IDLE & mem_op) | ACCESS | ERROR. Combinational; 0 in DONE.
//  FSM:
//   - IDLE, mem_op=0: stay in IDLE; stall_M=0.
//   - IDLE, mem_op=1, ALU_out_M[1:0]!=0: go to ERROR with cause 11; no request is issued.
//   - IDLE, mem_op=1, aligned: latch addr, wdata and we=memwrite_M; clear the counter; go to ACCESS.
//     If memtoreg_M and memwrite_M are both 1, the store takes precedence.
//   - ACCESS: dmem_req=1 (registered); the counter increments each cycle.
//   - ACCESS exit, in priority order:
//     1. dmem_err=1 -> ERROR, cause 01. dmem_err wins over a simultaneous ack.
//     2. dmem_ack=1 -> DONE. On a read, capture dmem_rdata into read_data_M.
//     3. counter==TIMEOUT-1 -> ERROR, cause 10.
//   - DONE: lasts 1 cycle; stall_M=0, dmem_req=0. The pipeline advances on this edge; next state is IDLE.
//   - ERROR: dmem_req=0; stall_M=1 indefinitely; bus_error=1.
//     err_cause and err_addr are written once, on entry. Only reset exits ERROR.
//  Timing:
//   - Minimum cost of a memory op is 3 cycles (IDLE, ACCESS with ack, DONE).
//   - Back-to-back memory ops each pay IDLE->ACCESS; there is no overlap.
//  Handshake:
//   - dmem_req/dmem_we/dmem_addr/dmem_wdata are registered and never glitch.
//   - dmem_req drops in the cycle after ack/err.
//   - ack or err outside ACCESS is ignored.
//  Reset mid-ACCESS:
//   - dmem_req drops asynchronously and nothing is captured.
//   - The memory side must tolerate the abandoned transaction.
//  read_data_M is unchanged by stores, errors and idle cycles.
// TESTING
//  1. Load at 0x100, ack on the 1st ACCESS cycle with rdata=0xDEADBEEF
//     -> stall_M=1 for 2 cycles, then 0.
//     -> read_data_M=0xDEADBEEF in DONE; dmem_we=0 throughout.
//  2. Store to 0x200 with data 0x12345678, ack after 4 ACCESS cycles
//     -> req/addr/wdata stable for 4 cycles; stall_M=1 for 5 cycles; read_data_M unchanged.
//  3. Load at 0x103 -> no dmem_req; bus_error=1, err_cause=11, err_addr=0x103; stall_M stuck at 1.
//  4. TIMEOUT=8, no ack -> ERROR after 8 ACCESS cycles with err_cause=10 and dmem_req=0.
//  5. ack and err asserted together in ACCESS -> err_cause=01; read_data_M not updated.
//  6. reset asserted in the 2nd ACCESS cycle -> outputs 0 immediately.
//     -> After release, a fresh load completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer for a variable-latency data memory.
// Issues one req/ack transaction per load/store and stalls the pipe.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memtoreg_M,
  input  logic        memwrite_M,
  input  logic [31:0] ALU_out_M,
  input  logic [31:0] write_data_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic        dmem_err,
  input  logic [31:0] dmem_rdata,
  output logic        stall_M,
  output logic [31:0] read_data_M,
  output logic        bus_error,
  output logic [1:0]  err_cause,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [1:0]      cause_q, cause_d;
  logic [31:0]     eaddr_q, eaddr_d;

  logic mem_op;
  logic misaligned;

  assign mem_op     = memtoreg_M | memwrite_M;
  assign misaligned = ALU_out_M[1:0] != 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cause_q <= 2'b00;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cause_q <= cause_d;
      eaddr_q <= eaddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cause_d = cause_q;
    eaddr_d = eaddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_op && misaligned) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          cause_d = 2'b11;
          eaddr_d = ALU_out_M;
        end else if (mem_op) begin
          state_d = S_ACCESS;
          req_d   = 1'b1;
          we_d    = memwrite_M;
          addr_d  = ALU_out_M;
          wdata_d = write_data_M;
          cnt_d   = '0;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // err beats a same-cycle ack; timeout only if neither arrives
        if (dmem_err) begin
          state_d = S_ERROR;
          req_d   = 1'b0;
          err_d   = 1'b1;
          cause_d = 2'b01;
          eaddr_d = addr_q;
        end else if (dmem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = dmem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
          req_d   = 1'b0;
          err_d   = 1'b1;
          cause_d = 2'b10;
          eaddr_d = addr_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_M = !reset &&
                   ((state_q == S_IDLE && mem_op) ||
                    state_q == S_ACCESS ||
                    state_q == S_ERROR);

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign read_data_M = rdata_q;
  assign bus_error   = err_q;
  assign err_cause   = cause_q;
  assign err_addr    = eaddr_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed table, hand sequences and
// randomized transactions against a per-transaction outcome model.
module tb_dmem_access_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        memtoreg_M, memwrite_M;
  logic [31:0] ALU_out_M, write_data_M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack, dmem_err;
  logic [31:0] dmem_rdata;
  logic        stall_M;
  logic [31:0] read_data_M;
  logic        bus_error;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;

  dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .memtoreg_M(memtoreg_M), .memwrite_M(memwrite_M),
    .ALU_out_M(ALU_out_M), .write_data_M(write_data_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_err(dmem_err),
    .dmem_rdata(dmem_rdata), .stall_M(stall_M),
    .read_data_M(read_data_M), .bus_error(bus_error),
    .err_cause(err_cause), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ld;
    bit          st;
    logic [31:0] a;
    logic [31:0] wd;
    int          k;
    bit          ack;
    bit          err;
    logic [31:0] rd;
    int          exp_stall;
    logic [1:0]  exp_cause;
  } vec_t;

  int          ncmp = 0;
  int          nerr = 0;
  logic [31:0] mdl_rd = '0;
  vec_t        tbl[$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit ld, bit st, logic [31:0] a,
                              logic [31:0] wd, int k, bit ack,
                              bit err, logic [31:0] rd,
                              int es, logic [1:0] ec);
    vec_t v;
    v.ld = ld; v.st = st; v.a = a; v.wd = wd; v.k = k;
    v.ack = ack; v.err = err; v.rd = rd;
    v.exp_stall = es; v.exp_cause = ec;
    return v;
  endfunction

  // Outcome of one transaction, from the memory's response alone
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    if (!(v.ld || v.st)) begin
      r.exp_cause = 2'd0; r.exp_stall = 0;
    end else if (v.a[1:0] != 2'b00) begin
      r.exp_cause = 2'd3; r.exp_stall = -1;
    end else if (v.k >= TO || !(v.ack || v.err)) begin
      r.exp_cause = 2'd2; r.exp_stall = -1;
    end else if (v.err) begin
      r.exp_cause = 2'd1; r.exp_stall = -1;
    end else begin
      r.exp_cause = 2'd0; r.exp_stall = v.k + 2;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    memtoreg_M = 1'b0; memwrite_M = 1'b0;
    dmem_ack = 1'b0; dmem_err = 1'b0;
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall_M), 32'd0);
    check("rst_err", {29'd0, bus_error, err_cause}, 32'd0);
    check("rst_eaddr", err_addr, 32'd0);
    check("rst_rdata", read_data_M, 32'd0);
    mdl_rd = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_op(input vec_t v);
    int  stalls = 0;
    int  reqs = 0;
    int  bad = 0;
    int  exp_req;
    bit  stuck = 1'b1;
    bit  op = v.ld || v.st;
    @(negedge clk);
    memtoreg_M = v.ld; memwrite_M = v.st;
    ALU_out_M = v.a; write_data_M = v.wd;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (!stall_M) begin
        stuck = 1'b0;
        break;
      end
      stalls++;
      if (dmem_req) begin
        if (dmem_addr !== v.a || dmem_we !== v.st ||
            dmem_wdata !== v.wd) bad++;
        dmem_ack = v.ack && reqs == v.k;
        dmem_err = v.err && reqs == v.k;
        dmem_rdata = (reqs == v.k) ? v.rd : $urandom;
        reqs++;
      end else begin
        dmem_ack = 1'($urandom);
        dmem_err = 1'($urandom);
        dmem_rdata = $urandom;
      end
    end
    if (v.exp_cause == 2'd0 && v.ld && !v.st) mdl_rd = v.rd;
    if (!op || v.exp_cause == 2'd3) exp_req = 0;
    else if (v.exp_cause == 2'd2) exp_req = TO;
    else exp_req = v.k + 1;
    if (v.exp_stall < 0) check("stall_stuck", 32'(stuck), 32'd1);
    else check("stall_cycles", stalls, v.exp_stall);
    check("req_cycles", reqs, exp_req);
    check("req_stable", bad, 32'd0);
    check("req_drop", 32'(dmem_req), 32'd0);
    check("read_data", read_data_M, mdl_rd);
    check("bus_error", 32'(bus_error), 32'(v.exp_cause != 2'd0));
    check("err_cause", 32'(err_cause), 32'(v.exp_cause));
    check("err_addr", err_addr,
          (v.exp_cause != 2'd0) ? v.a : 32'd0);
    dmem_ack = 1'b0; dmem_err = 1'b0;
    if (v.exp_cause != 2'd0) do_reset();
  endtask

  initial begin
    reset = 1'b1;
    memtoreg_M = 1'b0; memwrite_M = 1'b0;
    ALU_out_M = '0; write_data_M = '0;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
    #12;
    check("init_req", 32'(dmem_req), 32'd0);
    check("init_stall", 32'(stall_M), 32'd0);
    check("init_rdata", read_data_M, 32'd0);
    check("init_err", {29'd0, bus_error, err_cause}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    tbl.push_back(mk(1, 0, 32'h100, 32'h0, 0, 1, 0,
                     32'hDEADBEEF, 2, 2'd0));
    tbl.push_back(mk(0, 1, 32'h200, 32'h12345678, 3, 1, 0,
                     32'h0, 5, 2'd0));
    tbl.push_back(mk(1, 0, 32'h103, 32'h0, 0, 1, 0,
                     32'h0, -1, 2'd3));
    tbl.push_back(mk(1, 0, 32'h104, 32'h0, 1, 1, 0,
                     32'hA1B2C3D4, 3, 2'd0));
    tbl.push_back(mk(1, 0, 32'h40, 32'h0, 20, 1, 0,
                     32'h0, -1, 2'd2));
    tbl.push_back(mk(1, 0, 32'h108, 32'h0, 2, 1, 0,
                     32'h55AA55AA, 4, 2'd0));
    tbl.push_back(mk(1, 0, 32'h300, 32'h0, 1, 1, 1,
                     32'hFFFFFFFF, -1, 2'd1));
    tbl.push_back(mk(1, 0, 32'h10C, 32'h0, 0, 1, 0,
                     32'h0BADF00D, 2, 2'd0));
    tbl.push_back(mk(1, 1, 32'h44, 32'hA5A5A5A5, 2, 1, 0,
                     32'h0000FFFF, 4, 2'd0));
    tbl.push_back(mk(0, 0, 32'h47, 32'h0, 0, 0, 0,
                     32'h0, 0, 2'd0));
    tbl.push_back(mk(0, 1, 32'h202, 32'h1, 0, 1, 0,
                     32'h0, -1, 2'd3));
    tbl.push_back(mk(1, 0, 32'h110, 32'h0, TO - 1, 1, 0,
                     32'h13579BDF, TO + 1, 2'd0));
    tbl.push_back(mk(0, 1, 32'h114, 32'h2, TO - 1, 0, 1,
                     32'h0, -1, 2'd1));
    foreach (tbl[i]) do_op(tbl[i]);

    // reset in the 2nd ACCESS cycle, with an ack arriving meanwhile
    do_op(mk(1, 0, 32'h120, 32'h0, 0, 1, 0,
             32'h77777777, 2, 2'd0));
    @(negedge clk);
    memtoreg_M = 1'b1; ALU_out_M = 32'h80;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    memtoreg_M = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #1;
    check("midrst_req", 32'(dmem_req), 32'd0);
    check("midrst_stall", 32'(stall_M), 32'd0);
    check("midrst_rdata", read_data_M, 32'd0);
    mdl_rd = '0;
    @(negedge clk);
    reset = 1'b0; dmem_ack = 1'b0;
    do_op(mk(1, 0, 32'h84, 32'h0, 1, 1, 0,
             32'h2468ACE0, 3, 2'd0));

    for (int n = 0; n < 60; n++) begin
      vec_t v;
      int   kind = $urandom_range(0, 5);
      v.ld = 1'($urandom);
      v.st = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        v.ld = 1'b0; v.st = 1'b0;
      end
      v.a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) v.a[1:0] = 2'($urandom_range(1, 3));
      v.wd = $urandom;
      v.k = $urandom_range(0, TO + 1);
      v.ack = kind != 1 && kind != 5;
      v.err = kind == 1 || kind == 2;
      v.rd = $urandom;
      do_op(model(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
